conv1_mem_read: RTL and testbench

Address generator for reading the Convolution 1 output memory into the Pool 1 layer. It walks the 24x24 conv1 feature map as 144 non-overlapping 2x2 windows and issues four read addresses per window in raster-within-window order. It qualifies the returning memory data with valid and window-boundary flags aligned to the memory read latency. It sits between the conv1 output RAM read port and the max-pool datapath, and mirrors the conv1 write addresser on the read side.

---
 rtl/cnn_pkg.sv | 18 +
 rtl/conv1_mem_read_if.sv | 27 ++
 rtl/conv1_window_ctr.sv | 67 ++++++
 rtl/conv1_mem_read.sv | 114 +++++++++++
 tb/tb_conv1_mem_read.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN layer address generators.
// Map geometry and memory width here match the conv1 write-side addresser.
// conv1_rd_state_t encodes the conv1 output-memory read sequencer.
package cnn_pkg;

  localparam int CONV1_MAP_W      = 24;
  localparam int CONV1_MAP_H      = 24;
  localparam int POOL1_WINDOWS    = 144;
  localparam int CONV1_MEM_ADDR_W = 10;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_DRAIN,
    RD_DONE
  } conv1_rd_state_t;

endpackage

// File: rtl/conv1_mem_read_if.sv
// Read-side bundle between the conv1 memory addresser and the pool 1 stage.
// master = address generator, slave = sequencer / pool datapath side.
// Carries the run level, window-start backpressure, read address and beat flags.
interface conv1_mem_read_if #(
  parameter int ADDR_W = cnn_pkg::CONV1_MEM_ADDR_W
);

  logic              enable;
  logic              out_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic              data_valid;
  logic              win_first;
  logic              win_last;
  logic              done;

  modport master (
    input  enable, out_ready,
    output rd_addr, rd_en, data_valid, win_first, win_last, done
  );

  modport slave (
    output enable, out_ready,
    input  rd_addr, rd_en, data_valid, win_first, win_last, done
  );

endinterface

// File: rtl/conv1_window_ctr.sv
// Purpose: walks 2x2 windows of the feature map, producing the current read address.
// Latency: address is combinational from the counters; counters step on advance.
// Backpressure: counters hold whenever advance is low; clear reloads the map origin.
module conv1_window_ctr
  import cnn_pkg::*;
#(
  parameter int MAP_W     = CONV1_MAP_W,
  parameter int MAP_H     = CONV1_MAP_H,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = CONV1_MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        beat,
  output logic              last_win
);

  localparam int COL_W = (MAP_W > 2) ? $clog2(MAP_W / 2) : 1;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_WB  = ADDR_W'(BASE_ADDR + MAP_W * (MAP_H - 2) + MAP_W - 2);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(MAP_W / 2 - 1);

  logic [ADDR_W-1:0] wb;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] offset;

  // Raster order inside the window: top-left, top-right, bottom-left, bottom-right.
  always_comb begin
    case (beat)
      2'd0:    offset = '0;
      2'd1:    offset = ADDR_W'(1);
      2'd2:    offset = ADDR_W'(MAP_W);
      default: offset = ADDR_W'(MAP_W + 1);
    endcase
  end

  assign addr     = wb + offset;
  assign last_win = (wb == LAST_WB);

  // Step beat; after the fourth beat move right one window, or down to the next window row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb   <= BASE;
      col  <= '0;
      beat <= '0;
    end else if (clear) begin
      wb   <= BASE;
      col  <= '0;
      beat <= '0;
    end else if (advance) begin
      beat <= beat + 2'd1;
      if (beat == 2'd3) begin
        if (col == LAST_COL) begin
          col <= '0;
          wb  <= wb + ADDR_W'(MAP_W + 2);
        end else begin
          col <= col + COL_W'(1);
          wb  <= wb + ADDR_W'(2);
        end
      end
    end
  end

endmodule

// File: rtl/conv1_mem_read.sv
// Purpose: reads the conv1 output map as 2x2 windows for pool 1 and flags returning data.
// Latency: first rd_en the cycle after enable is seen; data flags trail rd_en by RD_LATENCY.
// Backpressure: enable=0 pauses; with CONV1_MEM_READ_BACKPRESSURE_EN, out_ready gates window starts.
module conv1_mem_read
  import cnn_pkg::*;
#(
  parameter int MAP_W      = CONV1_MAP_W,
  parameter int MAP_H      = CONV1_MAP_H,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_W     = CONV1_MEM_ADDR_W,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  conv1_mem_read_if.master bus
);

  // The whole map must be addressable and tile exactly into 2x2 windows.
  if (BASE_ADDR + MAP_W * MAP_H - 1 >= (1 << ADDR_W)) begin : g_bad_addr_range
    $error("conv1_mem_read: map does not fit in ADDR_W address bits");
  end
  if ((MAP_W % 2) != 0 || (MAP_H % 2) != 0) begin : g_bad_map_shape
    $error("conv1_mem_read: map dimensions must be even");
  end
  if (RD_LATENCY < 1) begin : g_bad_latency
    $error("conv1_mem_read: RD_LATENCY must be at least 1");
  end

  localparam int DCW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(RD_LATENCY - 1);

  conv1_rd_state_t   state, state_nxt;
  logic              start_ok;
  logic              issue;
  logic [ADDR_W-1:0] win_addr;
  logic [1:0]        beat;
  logic              last_win;
  logic [DCW-1:0]    drain_cnt;
  logic [RD_LATENCY-1:0] dv_sr, first_sr, last_sr;

`ifdef CONV1_MEM_READ_BACKPRESSURE_EN
  assign start_ok = bus.out_ready;
`else
  assign start_ok = 1'b1;
`endif

  // Backpressure is only consulted on beat 0 so a window's four reads stay contiguous.
  assign issue = (state == RD_ISSUE) && bus.enable && ((beat != 2'd0) || start_ok);

  conv1_window_ctr #(
    .MAP_W     (MAP_W),
    .MAP_H     (MAP_H),
    .BASE_ADDR (BASE_ADDR),
    .ADDR_W    (ADDR_W)
  ) u_win_ctr (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == RD_IDLE),
    .advance  (issue),
    .addr     (win_addr),
    .beat     (beat),
    .last_win (last_win)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RD_IDLE;
    else        state <= state_nxt;
  end

  // Sequence: wait for enable, issue all windows, let in-flight reads land, hold done.
  always_comb begin
    state_nxt = state;
    case (state)
      RD_IDLE:  if (bus.enable) state_nxt = RD_ISSUE;
      RD_ISSUE: if (issue && (beat == 2'd3) && last_win) state_nxt = RD_DRAIN;
      RD_DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = RD_DONE;
      RD_DONE:  if (!bus.enable) state_nxt = RD_IDLE;
      default:  state_nxt = RD_IDLE;
    endcase
  end

  // Port outputs; address reads as zero while idle so reset shows a clean bus.
  always_comb begin
    bus.rd_en   = issue;
    bus.rd_addr = (state == RD_IDLE) ? '0 : win_addr;
    bus.done    = (state == RD_DONE);
  end

  // Counts the RD_LATENCY drain cycles after the final read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 drain_cnt <= '0;
    else if (state != RD_DRAIN) drain_cnt <= '0;
    else                        drain_cnt <= drain_cnt + DCW'(1);
  end

  // Delay line aligning valid and window-edge flags with RAM read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dv_sr    <= '0;
      first_sr <= '0;
      last_sr  <= '0;
    end else begin
      dv_sr    <= (dv_sr << 1)    | RD_LATENCY'(issue);
      first_sr <= (first_sr << 1) | RD_LATENCY'(issue && (beat == 2'd0));
      last_sr  <= (last_sr << 1)  | RD_LATENCY'(issue && (beat == 2'd3));
    end
  end

  assign bus.data_valid = dv_sr[RD_LATENCY-1];
  assign bus.win_first  = first_sr[RD_LATENCY-1];
  assign bus.win_last   = last_sr[RD_LATENCY-1];

endmodule

// File: tb/tb_conv1_mem_read.sv
// Bench for conv1_mem_read: random and directed stimulus against a beat-count reference model.
// Model derives each address from the beat index with plain arithmetic over the 2x2 tiling.
// Output vector per cycle: {done, win_last, win_first, data_valid, rd_en, rd_en ? rd_addr : 0}.
module tb_conv1_mem_read;
  import cnn_pkg::*;

  localparam int LAT   = 2;
  localparam int MW    = 24;
  localparam int MH    = 24;
  localparam int AW    = 10;
  localparam int BEATS = MW * MH;

`ifdef CONV1_MEM_READ_BACKPRESSURE_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv1_mem_read_if #(.ADDR_W(AW)) bus ();

  conv1_mem_read #(
    .MAP_W(MW), .MAP_H(MH), .BASE_ADDR(0), .ADDR_W(AW), .RD_LATENCY(LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state: beats issued, run/done phases, drain count, flag pipe.
  int       m_k;
  bit       m_run;
  bit       m_done;
  int       m_drain;
  logic [2:0] m_pipe [LAT];

  logic [14:0] obs_v, exp_v;
  logic [AW-1:0] iss_q [$];
  int cnt_first, cnt_last, last_dv_cyc, first_done_cyc;

  function automatic int addr_of(input int k);
    int w, b;
    w = k / 4;
    b = k % 4;
    return (2 * (w / (MW / 2)) + b / 2) * MW + 2 * (w % (MW / 2)) + b % 2;
  endfunction

  function automatic bit model_en();
    return m_run && (m_k < BEATS) && bus.enable &&
           (((m_k % 4) != 0) || !BP || bus.out_ready);
  endfunction

  function automatic logic [14:0] model_vec();
    bit en;
    logic [AW-1:0] a;
    en = model_en();
    a  = en ? AW'(addr_of(m_k)) : '0;
    return {m_done, m_pipe[LAT-1][0], m_pipe[LAT-1][1], m_pipe[LAT-1][2], en, a};
  endfunction

  task automatic model_reset();
    m_k = 0; m_run = 0; m_done = 0; m_drain = 0;
    for (int i = 0; i < LAT; i++) m_pipe[i] = 3'b000;
  endtask

  task automatic model_tick();
    bit en;
    en = model_en();
    for (int i = LAT - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = {en, en && (m_k % 4 == 0), en && (m_k % 4 == 3)};
    if (m_done) begin
      if (!bus.enable) begin m_done = 0; m_k = 0; end
    end else if (!m_run) begin
      if (bus.enable) m_run = 1;
    end else if (m_k == BEATS) begin
      m_drain++;
      if (m_drain == LAT) begin m_run = 0; m_done = 1; m_drain = 0; end
    end else if (en) begin
      m_k++;
    end
  endtask

  // One clock: drive inputs, capture observed/expected at negedge, advance model at posedge.
  task automatic cycle_step(input bit en, input bit rdy);
    bus.enable    = en;
    bus.out_ready = rdy;
    @(negedge clk);
    obs_v = {bus.done, bus.win_last, bus.win_first, bus.data_valid, bus.rd_en,
             bus.rd_en ? bus.rd_addr : {AW{1'b0}}};
    exp_v = model_vec();
    if (bus.rd_en === 1'b1) iss_q.push_back(bus.rd_addr);
    if (bus.data_valid === 1'b1) begin
      last_dv_cyc = cyc;
      if (bus.win_first === 1'b1) cnt_first++;
      if (bus.win_last === 1'b1)  cnt_last++;
    end
    if (bus.done === 1'b1 && first_done_cyc < 0) first_done_cyc = cyc;
    @(posedge clk);
    model_tick();
    cyc++;
    #1;
  endtask

  task automatic restart();
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.out_ready = 1'b1;
    model_reset();
    iss_q.delete();
    cnt_first = 0; cnt_last = 0; last_dv_cyc = -1; first_done_cyc = -1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.enable = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    #3;
    n_checks++;
    if ({bus.done, bus.win_last, bus.win_first, bus.data_valid, bus.rd_en, bus.rd_addr} !== 15'h0) begin
      $display("FAIL reset_t0: outputs=%h required 0", {bus.done, bus.win_last, bus.win_first, bus.data_valid, bus.rd_en, bus.rd_addr});
    end else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.done, bus.data_valid, bus.rd_en, bus.rd_addr} !== 13'h0) begin
      $display("FAIL reset_held: outputs=%h required 0", {bus.done, bus.data_valid, bus.rd_en, bus.rd_addr});
    end else n_pass++;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle_step(1'b0, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL reset_idle cyc %0d: got %h expected %h", cyc, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_full_pass(input string name);
    logic [AW-1:0] exp8 [8];
    logic [AW-1:0] a48, a575;
    int diffs;
    exp8 = '{10'd0, 10'd1, 10'd24, 10'd25, 10'd2, 10'd3, 10'd26, 10'd27};
    iss_q.delete();
    cnt_first = 0; cnt_last = 0; last_dv_cyc = -1; first_done_cyc = -1;
    for (int i = 0; i < BEATS + LAT + 12; i++) begin
      cycle_step(1'b1, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL %s cyc %0d: got %h expected %h", name, cyc, obs_v, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (iss_q.size() != BEATS) $display("FAIL %s_count: got %0d reads required %0d", name, iss_q.size(), BEATS);
    else n_pass++;
    diffs = 0;
    for (int i = 0; i < 8; i++) if (iss_q.size() <= i || iss_q[i] !== exp8[i]) diffs++;
    n_checks++;
    if (diffs != 0) $display("FAIL %s_first8: %0d addresses differ from 0,1,24,25,2,3,26,27", name, diffs);
    else n_pass++;
    a48  = (iss_q.size() > 48)  ? iss_q[48]  : '1;
    a575 = (iss_q.size() > 575) ? iss_q[575] : '0;
    n_checks++;
    if (a48 !== 10'd48) $display("FAIL %s_win12: got %0d required 48", name, a48);
    else n_pass++;
    n_checks++;
    if (a575 !== 10'd575) $display("FAIL %s_lastaddr: got %0d required 575", name, a575);
    else n_pass++;
    n_checks++;
    if (cnt_first != POOL1_WINDOWS || cnt_last != POOL1_WINDOWS)
      $display("FAIL %s_winflags: first=%0d last=%0d required %0d", name, cnt_first, cnt_last, POOL1_WINDOWS);
    else n_pass++;
    n_checks++;
    if (first_done_cyc < 0 || first_done_cyc != last_dv_cyc + 1)
      $display("FAIL %s_done_timing: done at %0d required %0d", name, first_done_cyc, last_dv_cyc + 1);
    else n_pass++;
    diffs = 0;
    for (int i = 0; i < iss_q.size(); i++) if (iss_q[i] !== AW'(addr_of(i))) diffs++;
    n_checks++;
    if (diffs != 0) $display("FAIL %s_sequence: %0d addresses wrong", name, diffs);
    else n_pass++;
  endtask

  task automatic test_done_clear();
    for (int i = 0; i < 3; i++) begin
      cycle_step(1'b0, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL done_clear cyc %0d: got %h expected %h", cyc, obs_v, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL done_low: done=%b required 0", bus.done);
    else n_pass++;
  endtask

  task automatic test_pause();
    restart();
    for (int i = 0; i < 16; i++) begin
      cycle_step((i < 3 || i > 5) ? 1'b1 : 1'b0, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL pause cyc %0d: got %h expected %h", cyc, obs_v, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (iss_q.size() < 3 || iss_q[2] !== 10'd24)
      $display("FAIL pause_resume: third read=%0d required 24", (iss_q.size() > 2) ? int'(iss_q[2]) : -1);
    else n_pass++;
  endtask

  task automatic test_stall();
    int stall_en;
    restart();
    for (int i = 0; i < 40 && m_k < 12; i++) begin
      cycle_step(1'b1, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL stall_pre cyc %0d: got %h expected %h", cyc, obs_v, exp_v);
      else n_pass++;
    end
    stall_en = 0;
    for (int i = 0; i < 5; i++) begin
      cycle_step(1'b1, 1'b0);
      if (obs_v[AW] === 1'b1) stall_en++;
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL stall cyc %0d: got %h expected %h", cyc, obs_v, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (stall_en != (BP ? 0 : 5)) $display("FAIL stall_rd_en: got %0d reads required %0d", stall_en, BP ? 0 : 5);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      cycle_step(1'b1, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL stall_post cyc %0d: got %h expected %h", cyc, obs_v, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (iss_q.size() < 14 || iss_q[12] !== 10'd6 || iss_q[13] !== 10'd7)
      $display("FAIL stall_win3: window 3 start=%0d required 6", (iss_q.size() > 12) ? int'(iss_q[12]) : -1);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    restart();
    for (int i = 0; i < 20; i++) begin
      cycle_step(1'b1, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL midrun cyc %0d: got %h expected %h", cyc, obs_v, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (bus.data_valid !== m_pipe[LAT-1][2]) $display("FAIL midrun_inflight: data_valid=%b required %b", bus.data_valid, m_pipe[LAT-1][2]);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.done, bus.win_last, bus.win_first, bus.data_valid, bus.rd_en, bus.rd_addr} !== 15'h0)
      $display("FAIL midrun_async: outputs=%h required 0", {bus.done, bus.win_last, bus.win_first, bus.data_valid, bus.rd_en, bus.rd_addr});
    else n_pass++;
    model_reset();
    bus.enable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    iss_q.delete();
    for (int i = 0; i < 8; i++) begin
      cycle_step(1'b1, 1'b1);
      n_checks++;
      if (obs_v !== exp_v) $display("FAIL midrun_restart cyc %0d: got %h expected %h", cyc, obs_v, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (iss_q.size() == 0 || iss_q[0] !== 10'd0) $display("FAIL midrun_addr0: first read=%0d required 0", (iss_q.size() > 0) ? int'(iss_q[0]) : -1);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    restart();
    errs = 0;
    for (int i = 0; i < 2000; i++) begin
      cycle_step(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      n_checks++;
      if (obs_v !== exp_v) begin
        errs++;
        if (errs <= 20) $display("FAIL random cyc %0d: got %h expected %h", cyc, obs_v, exp_v);
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_full_pass("pass1");
    test_done_clear();
    test_full_pass("pass2");
    test_done_clear();
    test_pause();
    test_stall();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
